uart_frame_loader: RTL and testbench
====================================

# uart_frame_loader

Pixel source for the `st7735` driver: turns the UART byte stream into a 4-bit-indexed 80×40 cell framebuffer, where each cell is 2×2 LCD pixels, plus a 16-entry RGB565 palette. It answers the driver's `x`/`y` scan coordinates with `color`. It sits between `uart_receiver`/`uart_transmitter` and `st7735`, replacing the generated test pattern, and acknowledges each completed command back to the host.

## Interface
- `TIMEOUT_W`, 20: width of the inter-byte timeout counter. A partial command aborts after 2^TIMEOUT_W idle clocks, about 87 ms at 12 MHz.
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous, active-high reset.
- `rx_data  in  8`: byte from `uart_receiver`.
- `rx_valid  in  1`: one-cycle strobe; `rx_data` is valid in the same cycle.
- `tx_busy  in  1`: `uart_transmitter` busy.
- `tx_start  out  1`: one-cycle strobe that sends `tx_data`.
- `tx_data  out  8`: acknowledge/status byte.
- `x  in  8`: driver column, 0..159.
- `y  in  7`: driver row, 0..79.
- `color  out  16`: RGB565 value for (`x`,`y`).
- `busy  out  1`: high while FILL runs or a command is partially received.

## Operation
- **Command protocol.** First byte is the opcode; unknown opcodes in IDLE are dropped silently.
  - `0xA0 v`: fill every cell with index `v[3:0]`.
  - `0xA1 i hi lo`: palette entry `i[3:0]` = {hi,lo}.
  - `0xA2 cx cy v`: write cell (cx,cy) = `v[3:0]`.
    - Applies only if cx<80 and cy<40.
    - Otherwise nothing is written and the status is 0xE1.
  - `0xA3` followed by exactly 1600 bytes: full-frame upload.
    - Raster order, two cells per byte, high nibble = even cx.
- **FSM states.**
  - IDLE: opcode → GET_A.
  - GET_A: arg byte; `0xA0` → FILL, `0xA3` enters STREAM directly from IDLE.
  - GET_B: arg byte.
  - GET_C: arg byte → execute → IDLE.
  - STREAM: 1600-byte counter → IDLE.
  - FILL: write address 0..3199, one per clock → IDLE.
- **Rx during FILL.** `rx_valid` in FILL is discarded; the host must wait for the ack.
- **Timeout.** Counter clears on every `rx_valid`. Saturation in GET_A/B/C or STREAM returns to IDLE with status 0xE2. Cells already written stay written.
- **Ack.** Every command completion or abort sets `ack_pend` and latches the status: 0x00 OK, 0xE1 bad coordinate, 0xE2 timeout.
  - When `ack_pend` && !`tx_busy`, pulse `tx_start` for one clock and clear `ack_pend`.
  - A newer status overwrites an unsent one.
- **Address arithmetic.** Cell address = cy*64 + cy*16 + cx, 12 bits, shift-add only, no multiplier.
  - Read side uses cx = x[7:1], cy = y[6:1].
- **Palette.** 16×16 register file.
  - Reset value of entry i = {i, i[3], i, i[3:2], i, i[3]}, i.e. grayscale: 0→0x0000, 15→0xFFFF.
  - Framebuffer RAM contents are not reset.
- **Out-of-range read.** x≥160 or y≥80 gives `color` = 0x0000.

## Timing
- **Reset values.** `tx_start`=0, `tx_data`=0x00, `color`=0x0000, `busy`=0, FSM=IDLE, `ack_pend`=0, timeout counter=0.
- **Reset mid-operation.** Immediate IDLE; the pending ack and FILL are abandoned.
- **Read latency.** 2 clocks from `x`/`y` to `color`: RAM registered read, then palette lookup register.
  - Holds for any `x`/`y` change.
  - `st7735` holds `x`/`y` for ≥16 clocks per pixel, so this latency is sufficient.
- **Write/read independence.** Writes use the RAM write port, scan reads use the read port.
  - A read of a cell written in the same cycle returns the old value.
- **Write latency.**
  - A2 cell write lands 1 clock after the `rx_valid` of `v`.
  - A1 palette write lands 1 clock after `lo`.
- **FILL duration.** 3200 clocks; status 0x00 queued the clock after address 3199 is written.
- **Ack timing.** `tx_start` no earlier than 1 clock after status is latched; never while `tx_busy`=1.
- **Simultaneous events.** `rx_valid` and timeout saturation in the same clock: the byte wins and the counter clears.

## Structure
- **Package `frame_loader_pkg`.**
  - Opcodes `OP_FILL`/`OP_PAL`/`OP_CELL`/`OP_FRAME`.
  - Status codes `ST_OK`/`ST_BADXY`/`ST_TIMEOUT`.
  - `FB_W`=80, `FB_H`=40, `FB_DEPTH`=3200, `FRAME_BYTES`=1600.
  - FSM state enum.
- **Sub-module `cell_ram`.** 4096×4 simple dual-port RAM: one write port, one registered read port. Inferable to iCE40 block RAM.

## Test plan
- **Reset palette.** After reset, `A0 0F` then scan (0,0) → `color`=0xFFFF 2 clocks after `x`/`y`; ack byte 0x00.
- **Palette then cell write.** `A1 03 F8 00` then `A2 05 02 03` → x=10/11, y=4/5 give 0xF800; x=12,y=4 unchanged. Two acks, both 0x00.
- **Bad coordinate.** `A2 50 00 01` → no RAM write, ack 0xE1.
- **Frame upload.** `A3` + 1600 bytes of 0x12 → even cx=index 1, odd cx=index 2 across the whole frame; single ack 0x00 after byte 1600.
- **Timeout and recovery.** `A1 02` then silence for 2^20 clocks → ack 0xE2, FSM IDLE, palette unchanged. Next `A1 02 07 E0` succeeds.
- **Busy, FILL and reset.**
  - Ack raised with `tx_busy`=1 → `tx_start` held until `tx_busy` falls.
  - `rx_valid` during FILL is ignored.
  - `rst` mid-FILL → `busy`=0 the next clock; no ack sent.

Source files
------------

// File: rtl/frame_loader_pkg.sv
// rtl/frame_loader_pkg.sv - shared constants, state enum and address helpers for uart_frame_loader
//
// Purpose: opcodes, status codes, framebuffer geometry, FSM state type and
// the shift-add cell address / grayscale palette helpers.
// Ports: none (package).

package frame_loader_pkg;

  localparam logic [7:0] OP_FILL  = 8'hA0;
  localparam logic [7:0] OP_PAL   = 8'hA1;
  localparam logic [7:0] OP_CELL  = 8'hA2;
  localparam logic [7:0] OP_FRAME = 8'hA3;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADXY   = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT = 8'hE2;

  localparam logic [7:0]  FB_W        = 8'd80;
  localparam logic [7:0]  FB_H        = 8'd40;
  localparam logic [11:0] FB_DEPTH    = 12'd3200;
  localparam logic [10:0] FRAME_BYTES = 11'd1600;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_GET_C,
    S_STREAM,
    S_FILL
  } state_t;

  // cy*80 + cx as cy*64 + cy*16 + cx, no multiplier.
  function automatic logic [11:0] cell_addr(input logic [6:0] cx, input logic [5:0] cy);
    return {cy, 6'b0} + {2'b0, cy, 4'b0} + {5'b0, cx};
  endfunction

  // Grayscale RGB565 by bit replication of the 4-bit index.
  function automatic logic [15:0] gray565(input logic [3:0] i);
    return {i, i[3], i, i[3:2], i, i[3]};
  endfunction

endpackage

// File: rtl/cell_ram.sv
// rtl/cell_ram.sv - 4096x4 simple dual-port RAM, one write port, one registered read port
//
// Purpose: framebuffer storage of 4-bit palette indices.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - registered read data (old value on same-cycle write)

module cell_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [11:0] waddr,
  input  logic [3:0]  wdata,
  input  logic [11:0] raddr,
  output logic [3:0]  rdata
);

  logic [3:0] mem [0:4095];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - UART command decoder feeding an 80x40 4-bit framebuffer and RGB565 palette
//
// Purpose: decodes FILL / PALETTE / CELL / FRAME commands from the UART byte
// stream, owns the framebuffer and palette, answers scan coordinates with a
// colour two clocks later, and acknowledges each command with a status byte.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   rx_data, rx_valid - received byte and its one-cycle strobe
//   tx_busy           - transmitter busy
//   tx_start, tx_data - one-cycle send strobe and status byte
//   x, y              - scan coordinate (160x80 LCD pixels)
//   color             - RGB565 for (x, y), 2-clock latency
//   busy              - command in progress or FILL running

module uart_frame_loader
  import frame_loader_pkg::*;
#(
  parameter int TIMEOUT_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  output logic [15:0] color,
  output logic        busy
);

  state_t               state;
  logic [7:0]           op;
  logic [7:0]           arg_a;
  logic [7:0]           arg_b;
  logic [11:0]          fill_cnt;
  logic [3:0]           fill_val;
  logic [10:0]          byte_cnt;
  logic                 odd_pend;
  logic [11:0]          odd_addr;
  logic [3:0]           odd_val;
  logic [TIMEOUT_W-1:0] tmo;
  logic                 ack_pend;
  logic [7:0]           status;
  logic [15:0]          palette [16];

  logic                 we;
  logic [11:0]          waddr;
  logic [3:0]           wdata;
  logic [11:0]          raddr;
  logic [3:0]           rd_idx;
  logic                 oor_q;
  logic                 coord_ok;

  assign busy     = (state != S_IDLE);
  assign coord_ok = (arg_a < FB_W) && (arg_b < FB_H);
  assign raddr    = cell_addr(x[7:1], y[6:1]);

  // One write port shared by all writers. A FRAME byte carries two cells:
  // the even cell goes in on the byte itself, the odd one the clock after.
  // UART bytes are always at least two clocks apart, so they never collide.
  always_comb begin
    we    = 1'b0;
    waddr = 12'd0;
    wdata = 4'd0;
    if (odd_pend) begin
      we    = 1'b1;
      waddr = odd_addr;
      wdata = odd_val;
    end else if (state == S_FILL) begin
      we    = 1'b1;
      waddr = fill_cnt;
      wdata = fill_val;
    end else if (rx_valid && state == S_STREAM) begin
      we    = 1'b1;
      waddr = {byte_cnt, 1'b0};
      wdata = rx_data[7:4];
    end else if (rx_valid && state == S_GET_C && op == OP_CELL && coord_ok) begin
      we    = 1'b1;
      waddr = cell_addr(arg_a[6:0], arg_b[5:0]);
      wdata = rx_data[3:0];
    end
  end

  cell_ram u_cell_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rd_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op       <= 8'd0;
      arg_a    <= 8'd0;
      arg_b    <= 8'd0;
      fill_cnt <= 12'd0;
      fill_val <= 4'd0;
      byte_cnt <= 11'd0;
      odd_pend <= 1'b0;
      odd_addr <= 12'd0;
      odd_val  <= 4'd0;
      tmo      <= '0;
      ack_pend <= 1'b0;
      status   <= ST_OK;
      tx_start <= 1'b0;
      tx_data  <= 8'd0;
      for (int i = 0; i < 16; i++) begin
        palette[i] <= gray565(4'(i));
      end
    end else begin
      tx_start <= 1'b0;
      odd_pend <= 1'b0;
      if (ack_pend && !tx_busy) begin
        tx_start <= 1'b1;
        tx_data  <= status;
        ack_pend <= 1'b0;
      end

      // A byte in the same clock as saturation wins: it clears the counter
      // and is processed below, so the abort branch is never reached.
      if (rx_valid || state == S_IDLE || state == S_FILL) begin
        tmo <= '0;
      end else if (tmo != '1) begin
        tmo <= tmo + TIMEOUT_W'(1);
      end

      // Completion/abort below assigns ack_pend/status after the send
      // logic above, so a newer status overwrites an unsent one.
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            op <= rx_data;
            if (rx_data == OP_FRAME) begin
              byte_cnt <= 11'd0;
              state    <= S_STREAM;
            end else if (rx_data == OP_FILL || rx_data == OP_PAL || rx_data == OP_CELL) begin
              state <= S_GET_A;
            end
          end
        end
        S_GET_A: begin
          if (rx_valid) begin
            arg_a <= rx_data;
            if (op == OP_FILL) begin
              fill_val <= rx_data[3:0];
              fill_cnt <= 12'd0;
              state    <= S_FILL;
            end else begin
              state <= S_GET_B;
            end
          end else if (tmo == '1) begin
            state    <= S_IDLE;
            ack_pend <= 1'b1;
            status   <= ST_TIMEOUT;
          end
        end
        S_GET_B: begin
          if (rx_valid) begin
            arg_b <= rx_data;
            state <= S_GET_C;
          end else if (tmo == '1) begin
            state    <= S_IDLE;
            ack_pend <= 1'b1;
            status   <= ST_TIMEOUT;
          end
        end
        S_GET_C: begin
          if (rx_valid) begin
            state    <= S_IDLE;
            ack_pend <= 1'b1;
            if (op == OP_PAL) begin
              palette[arg_a[3:0]] <= {arg_b, rx_data};
              status              <= ST_OK;
            end else begin
              status <= coord_ok ? ST_OK : ST_BADXY;
            end
          end else if (tmo == '1) begin
            state    <= S_IDLE;
            ack_pend <= 1'b1;
            status   <= ST_TIMEOUT;
          end
        end
        S_STREAM: begin
          if (rx_valid) begin
            odd_pend <= 1'b1;
            odd_addr <= {byte_cnt, 1'b1};
            odd_val  <= rx_data[3:0];
            if (byte_cnt == FRAME_BYTES - 11'd1) begin
              state    <= S_IDLE;
              ack_pend <= 1'b1;
              status   <= ST_OK;
            end else begin
              byte_cnt <= byte_cnt + 11'd1;
            end
          end else if (tmo == '1) begin
            state    <= S_IDLE;
            ack_pend <= 1'b1;
            status   <= ST_TIMEOUT;
          end
        end
        S_FILL: begin
          // Incoming bytes are deliberately ignored here.
          if (fill_cnt == FB_DEPTH - 12'd1) begin
            state    <= S_IDLE;
            ack_pend <= 1'b1;
            status   <= ST_OK;
          end else begin
            fill_cnt <= fill_cnt + 12'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read pipeline: RAM registered read, then palette lookup register.
  // The out-of-range flag travels alongside the RAM stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      oor_q <= 1'b0;
      color <= 16'h0000;
    end else begin
      oor_q <= (x >= {FB_W[6:0], 1'b0}) || (y >= {FB_H[5:0], 1'b0});
      color <= oor_q ? 16'h0000 : palette[rd_idx];
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - self-checking bench for uart_frame_loader

module tb_uart_frame_loader;

  localparam int TW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        force_busy;
  logic        uart_busy;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [15:0] color;
  logic        busy;

  assign tx_busy = force_busy | uart_busy;

  always #5 clk = ~clk;

  uart_frame_loader #(.TIMEOUT_W(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .x        (x),
    .y        (y),
    .color    (color),
    .busy     (busy)
  );

  int          total = 0;
  int          bad = 0;
  logic [3:0]  m_fb [3200];
  logic [15:0] m_pal [16];
  logic [7:0]  exp_ack [$];
  bit          chk_en = 0;
  bit          fb_known = 0;
  int          n_starts = 0;
  logic [7:0]  last_ack = 8'hFF;
  int          stab = 0;
  logic [7:0]  px = 8'd0;
  logic [6:0]  py = 7'd0;
  bit          prev_busy = 0;

  function automatic logic [15:0] gray(input int i);
    logic [3:0] b;
    b = 4'(i);
    return {b, b[3], b, b[3:2], b, b[3]};
  endfunction

  function automatic logic [15:0] model_color(input int xx, input int yy);
    if (xx >= 160 || yy >= 80) return 16'h0000;
    return m_pal[m_fb[(yy / 2) * 80 + xx / 2]];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Compare process: colour on every settled scan cycle, ack bytes on every tx_start.
  always @(negedge clk) begin
    if (x == px && y == py) stab++;
    else stab = 0;
    px = x;
    py = y;
    if (!rst && chk_en && stab >= 2)
      check("color", 32'(color), 32'(model_color(int'(x), int'(y))));
    if (!rst && tx_start) begin
      n_starts++;
      check("tx_busy_at_start", 32'(prev_busy), 32'd0);
      if (exp_ack.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ack_unexpected: got %0h, required none", tx_data);
      end else begin
        check("ack", 32'(tx_data), 32'(exp_ack.pop_front()));
      end
      last_ack = tx_data;
    end
    prev_busy = tx_busy;
  end

  // Transmitter model: busy for a random stretch after each start.
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        uart_busy = 1'b1;
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, required finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (exp_ack.size() != 0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    if (exp_ack.size() != 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: %0d acks outstanding, required 0", exp_ack.size());
      exp_ack.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk_en = fb_known;
  endtask

  task automatic look(input int xx, input int yy, input logic [15:0] exp, input string name);
    @(posedge clk);
    #1;
    x = 8'(xx);
    y = 7'(yy);
    repeat (2) @(posedge clk);
    #1;
    check(name, 32'(color), 32'(exp));
  endtask

  task automatic scan_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      x = 8'($urandom_range(0, 200));
      y = 7'($urandom_range(0, 100));
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic cmd_fill(input logic [3:0] v);
    chk_en = 0;
    exp_ack.push_back(8'h00);
    send_byte(8'hA0);
    send_byte({4'($urandom), v});
    for (int i = 0; i < 3200; i++) m_fb[i] = v;
    fb_known = 1;
    wait_ack();
  endtask

  task automatic cmd_pal(input int i, input logic [15:0] val);
    chk_en = 0;
    exp_ack.push_back(8'h00);
    send_byte(8'hA1);
    send_byte({4'($urandom), 4'(i)});
    send_byte(val[15:8]);
    send_byte(val[7:0]);
    m_pal[i] = val;
    wait_ack();
  endtask

  task automatic cmd_cell(input int cx, input int cy, input logic [3:0] v);
    chk_en = 0;
    if (cx < 80 && cy < 40) begin
      m_fb[cy * 80 + cx] = v;
      exp_ack.push_back(8'h00);
    end else begin
      exp_ack.push_back(8'hE1);
    end
    send_byte(8'hA2);
    send_byte(8'(cx));
    send_byte(8'(cy));
    send_byte({4'($urandom), v});
    wait_ack();
  endtask

  task automatic cmd_frame(input bit use_const, input logic [7:0] cval, input int nbytes);
    logic [7:0] b;
    chk_en = 0;
    exp_ack.push_back(nbytes == 1600 ? 8'h00 : 8'hE2);
    send_byte(8'hA3);
    for (int k = 0; k < nbytes; k++) begin
      b = use_const ? cval : 8'($urandom);
      m_fb[2 * k]     = b[7:4];
      m_fb[2 * k + 1] = b[3:0];
      send_byte(b);
    end
    wait_ack();
  endtask

  initial begin
    int n0;
    logic [3:0] v;
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    force_busy = 1'b0;
    x          = 8'd0;
    y          = 7'd0;
    for (int i = 0; i < 16; i++) m_pal[i] = gray(i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'h00);
    check("reset_color", 32'(color), 32'h0000);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Reset palette: index 15 is white.
    cmd_fill(4'hF);
    look(0, 0, 16'hFFFF, "fill_white_0_0");
    check("fill_ack", 32'(last_ack), 32'h00);

    // Palette then cell write, with 2-clock read latency.
    cmd_pal(3, 16'hF800);
    cmd_cell(5, 2, 4'h3);
    check("cell_ack", 32'(last_ack), 32'h00);
    look(12, 4, 16'hFFFF, "cell_neighbour");
    @(posedge clk);
    #1;
    x = 8'd10;
    @(posedge clk);
    #1;
    check("latency_1clk_old", 32'(color), 32'hFFFF);
    @(posedge clk);
    #1;
    check("latency_2clk_new", 32'(color), 32'hF800);
    look(11, 5, 16'hF800, "cell_2x2");

    // Bad coordinates.
    cmd_cell(80, 0, 4'h1);
    check("badx_ack", 32'(last_ack), 32'hE1);
    look(0, 2, 16'hFFFF, "badx_no_wrap");
    cmd_cell(0, 40, 4'h1);
    check("bady_ack", 32'(last_ack), 32'hE1);

    // Unknown opcode is dropped.
    send_byte(8'h55);
    check("unknown_op_idle", 32'(busy), 32'd0);

    // Frame upload of 0x12.
    cmd_frame(1'b1, 8'h12, 1600);
    check("frame_ack", 32'(last_ack), 32'h00);
    look(0, 0, 16'h1082, "frame_even");
    look(2, 0, 16'h2104, "frame_odd");
    look(158, 79, 16'h2104, "frame_last");
    look(1, 1, 16'h1082, "frame_first_2x2");
    look(160, 0, 16'h0000, "oor_x");
    look(0, 80, 16'h0000, "oor_y");

    // Timeout, then recovery with a gap just under the limit.
    chk_en = 0;
    exp_ack.push_back(8'hE2);
    send_byte(8'hA1);
    send_byte(8'h02);
    check("busy_partial", 32'(busy), 32'd1);
    wait_ack();
    check("timeout_ack", 32'(last_ack), 32'hE2);
    check("timeout_idle", 32'(busy), 32'd0);
    look(2, 0, 16'h2104, "timeout_pal_kept");
    chk_en = 0;
    exp_ack.push_back(8'h00);
    send_byte(8'hA1);
    send_byte(8'h02);
    repeat ((1 << TW) - 60) @(posedge clk);
    send_byte(8'h07);
    send_byte(8'hE0);
    m_pal[2] = 16'h07E0;
    wait_ack();
    look(2, 0, 16'h07E0, "recover_pal");

    // Timeouts mid-stream and mid-cell command.
    cmd_frame(1'b0, 8'h00, 5);
    chk_en = 0;
    exp_ack.push_back(8'hE2);
    send_byte(8'hA2);
    send_byte(8'd3);
    send_byte(8'd4);
    wait_ack();
    scan_random(8);

    // Ack held off by tx_busy.
    @(posedge clk);
    #1;
    force_busy = 1'b1;
    chk_en = 0;
    exp_ack.push_back(8'h00);
    send_byte(8'hA1);
    send_byte(8'h05);
    send_byte(8'h12);
    send_byte(8'h34);
    m_pal[5] = 16'h1234;
    n0 = n_starts;
    repeat (40) @(posedge clk);
    check("held_by_busy", 32'(n_starts), 32'(n0));
    #1 force_busy = 1'b0;
    wait_ack();
    check("released_ack", 32'(n_starts), 32'(n0 + 1));

    // Bytes during FILL are ignored.
    chk_en = 0;
    v = 4'($urandom);
    exp_ack.push_back(8'h00);
    send_byte(8'hA0);
    send_byte({4'h0, v});
    send_byte(8'hA2);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h0E);
    for (int i = 0; i < 3200; i++) m_fb[i] = v;
    wait_ack();
    scan_random(6);

    // Reset in the middle of FILL.
    chk_en = 0;
    send_byte(8'hA0);
    send_byte(8'h07);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_fill_busy", 32'(busy), 32'd0);
    fb_known = 0;
    for (int i = 0; i < 16; i++) m_pal[i] = gray(i);
    n0 = n_starts;
    repeat (300) @(posedge clk);
    check("rst_no_ack", 32'(n_starts), 32'(n0));
    cmd_fill(4'($urandom));

    // Randomized traffic.
    for (int it = 0; it < 50; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: cmd_pal(int'($urandom_range(0, 15)), 16'($urandom));
        3, 4, 5, 6, 7: cmd_cell(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 79)),
                                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 39)),
                                4'($urandom));
        default: scan_random(2);
      endcase
      scan_random(3);
    end
    cmd_frame(1'b0, 8'h00, 1600);
    scan_random(20);
    cmd_cell(79, 39, 4'h9);
    look(159, 79, m_pal[9], "last_cell");

    check("ack_queue_drained", 32'(exp_ack.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
